// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the IF/MEM shared-memory arbiter.
package riscv_mem_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_sel_t;

    // Instruction words are 32-bit halves of the 64-bit memory word.
    function automatic logic [ILEN-1:0] fetch_word(input logic [XLEN-1:0] dword,
                                                   input logic            upper);
        return upper ? dword[XLEN-1:ILEN] : dword[ILEN-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request ports and memory-side access bus of the arbiter.
interface mem_port_arbiter_if;
    import riscv_mem_pkg::*;

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ack;
    logic [ILEN-1:0] if_rdata;
    logic            if_wait;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;
    logic            d_wait;

    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    logic            busy;

    // The arbiter serves the requesters and drives the memory.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_wait, d_ack, d_rdata, d_wait,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Pipeline stages plus memory model, seen from outside the arbiter.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_wait, d_ack, d_rdata, d_wait,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that flags when the memory read latency has elapsed.
module mem_lat_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and data access,
// data first, with a starvation counter that eventually forces a pending fetch through.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] LAT_LOAD   = TW'(MEM_LAT - 1);

    arb_state_t      state;
    port_sel_t       grant;
    logic            grant_we;
    logic [SW-1:0]   starve_cnt;

    port_sel_t       pick;
    logic            pick_valid;
    logic            tmr_done;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick_valid = bus.if_req | bus.d_req;
        pick       = PORT_D;
        if (bus.if_req && (!bus.d_req || starve_cnt == STARVE_MAX)) begin
            pick = PORT_IF;
        end
    end

    mem_lat_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ISSUE),
        .en       (state == WAIT),
        .load_val (LAT_LOAD),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= PORT_IF;
            grant_we      <= 1'b0;
            starve_cnt    <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state         <= ISSUE;
                        grant         <= pick;
                        grant_we      <= (pick == PORT_D) && bus.d_we;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= (pick == PORT_D) && bus.d_we;
                        bus.mem_addr  <= (pick == PORT_D) ? bus.d_addr : bus.if_addr;
                        bus.mem_wdata <= (pick == PORT_D) ? bus.d_wdata : '0;
                        // Only data wins that pass over a waiting fetch count toward starvation.
                        if (pick == PORT_IF) begin
                            starve_cnt <= '0;
                        end else if (bus.if_req && starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                ISSUE: begin
                    state      <= WAIT;
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                end
                WAIT: begin
                    if (tmr_done) begin
                        state <= RESP;
                        if (grant == PORT_IF) begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= fetch_word(bus.mem_rdata, bus.mem_addr[2]);
                        end else begin
                            bus.d_ack <= 1'b1;
                            if (!grant_we) begin
                                bus.d_rdata <= bus.mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.if_wait = bus.if_req & ~bus.if_ack;
    assign bus.d_wait  = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: table-driven single accesses, contention/starvation sequences,
// and a reset-in-WAIT sequence on a second instance with MEM_LAT=3.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    typedef struct {
        port_sel_t   port;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        port_sel_t   port;
        logic [63:0] data;
        logic        chk;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    logic reset3;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if ifc ();
    mem_port_arbiter_if ifc3 ();

    mem_port_arbiter #(.MEM_LAT(LAT1), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    mem_port_arbiter #(.MEM_LAT(LAT3), .STARVE_LIMIT(4)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (ifc3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model for the MEM_LAT=1 instance: data valid only in the cycle after mem_en.
    logic [63:0] mem [0:255];
    always @(posedge clk) begin
        if (ifc.mem_en) begin
            if (ifc.mem_we) mem[ifc.mem_addr[10:3]] <= ifc.mem_wdata;
            ifc.mem_rdata <= mem[ifc.mem_addr[10:3]];
        end else begin
            ifc.mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    // Scoreboard and bus monitor.
    sb_t         exp_q[$];
    int          mem_en_cnt = 0;
    int          ack_cnt = 0;
    int          en3_cnt = 0;
    int          ack3_cnt = 0;
    logic [63:0] last_addr;
    logic [63:0] last_wdata;
    logic        last_we;
    logic        prev_if_req = 1'b0, prev_if_ack = 1'b0;
    logic        prev_d_req = 1'b0, prev_d_ack = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            sb_t e;
            if (ifc.mem_en) begin
                mem_en_cnt++;
                last_addr  = ifc.mem_addr;
                last_wdata = ifc.mem_wdata;
                last_we    = ifc.mem_we;
            end
            if (ifc.if_ack && ifc.d_ack) check("dual_ack", 1, 0);
            if (ifc.if_ack || ifc.d_ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", ifc.d_ack ? PORT_D : PORT_IF, e.port);
                    if (e.chk) check("rdata", ifc.d_ack ? ifc.d_rdata : {32'b0, ifc.if_rdata}, e.data);
                end
            end
            if (ifc.if_req) check("if_wait", ifc.if_wait, !ifc.if_ack);
            if (ifc.d_req)  check("d_wait", ifc.d_wait, !ifc.d_ack);
            if (prev_if_req && !ifc.if_req && !prev_if_ack) check("if_req_dropped_early", 1, 0);
            if (prev_d_req && !ifc.d_req && !prev_d_ack) check("d_req_dropped_early", 1, 0);
            prev_if_req = ifc.if_req;
            prev_if_ack = ifc.if_ack;
            prev_d_req  = ifc.d_req;
            prev_d_ack  = ifc.d_ack;
        end
        if (ifc3.mem_en) en3_cnt++;
        if (ifc3.d_ack) ack3_cnt++;
        if (ifc3.if_ack) check("dut3_spurious_if_ack", 1, 0);
    end

    task automatic fetch_req(input logic [63:0] addr, output int lat);
        int t0;
        @(posedge clk); #1;
        ifc.if_req  = 1'b1;
        ifc.if_addr = addr;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifc.if_ack) begin
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk); #1;
        ifc.if_req = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            output int lat);
        int t0;
        @(posedge clk); #1;
        ifc.d_req   = 1'b1;
        ifc.d_we    = we;
        ifc.d_addr  = addr;
        ifc.d_wdata = wdata;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifc.d_ack) begin
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk); #1;
        ifc.d_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int en0;
        en0 = mem_en_cnt;
        exp_q.push_back('{port: v.port, data: v.exp, chk: !(v.port == PORT_D && v.we)});
        if (v.port == PORT_IF) fetch_req(v.addr, lat);
        else                   data_req(v.we, v.addr, v.wdata, lat);
        check("req_to_ack_latency", 64'(lat), 64'(LAT1 + 2));
        check("mem_en_pulses", 64'(mem_en_cnt - en0), 64'd1);
        check("issue_addr", last_addr, v.addr);
        check("issue_we", {63'b0, last_we}, {63'b0, v.port == PORT_D && v.we});
        if (v.port == PORT_D && v.we) check("issue_wdata", last_wdata, v.wdata);
    endtask

    vec_t vecs[9];

    initial begin
        int lat_d, lat_i, nd, nd_at_if, r, lat3, en3_0, ack3_0;
        logic got_if, done_s;

        vecs[0] = '{PORT_IF, 1'b0, 64'h4,   64'h0,                   64'hAAAA_BBBB};
        vecs[1] = '{PORT_IF, 1'b0, 64'h0,   64'h0,                   64'h0000_0013};
        vecs[2] = '{PORT_D,  1'b1, 64'h100, 64'h1234,                64'h0};
        vecs[3] = '{PORT_D,  1'b0, 64'h100, 64'h0,                   64'h1234};
        vecs[4] = '{PORT_D,  1'b1, 64'h108, 64'hFEDC_BA98_7654_3210, 64'h0};
        vecs[5] = '{PORT_IF, 1'b0, 64'h10C, 64'h0,                   64'hFEDC_BA98};
        vecs[6] = '{PORT_IF, 1'b0, 64'h108, 64'h0,                   64'h7654_3210};
        vecs[7] = '{PORT_D,  1'b0, 64'h108, 64'h0,                   64'hFEDC_BA98_7654_3210};
        vecs[8] = '{PORT_D,  1'b0, 64'h200, 64'h0,                   64'h0123_4567_89AB_CDEF};

        for (int i = 0; i < 256; i++) mem[i] = {32'hC0DE_0000, 32'(i)};
        mem[0]    = 64'hAAAA_BBBB_0000_0013;
        mem[8'h40] = 64'h0123_4567_89AB_CDEF;

        reset  = 1'b1;
        reset3 = 1'b1;
        ifc.if_req = 1'b0;  ifc.if_addr = '0;
        ifc.d_req  = 1'b0;  ifc.d_we = 1'b0;  ifc.d_addr = '0;  ifc.d_wdata = '0;
        ifc3.if_req = 1'b0; ifc3.if_addr = '0;
        ifc3.d_req  = 1'b0; ifc3.d_we = 1'b0; ifc3.d_addr = '0; ifc3.d_wdata = '0;
        ifc3.mem_rdata = 64'h5555_6666_7777_8888;

        repeat (2) @(negedge clk);
        check("rst_busy",     {63'b0, ifc.busy},   64'd0);
        check("rst_mem_en",   {63'b0, ifc.mem_en}, 64'd0);
        check("rst_mem_addr", ifc.mem_addr,        64'd0);
        check("rst_acks",     {62'b0, ifc.if_ack, ifc.d_ack}, 64'd0);
        check("rst_rdata",    ifc.d_rdata | {32'b0, ifc.if_rdata}, 64'd0);
        reset  = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);
        check("idle_busy", {63'b0, ifc.busy}, 64'd0);

        // Single accesses from the table.
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Simultaneous requests: data first, fetch MEM_LAT+3 cycles after d_ack.
        exp_q.push_back('{port: PORT_D,  data: 64'h1234,        chk: 1'b1});
        exp_q.push_back('{port: PORT_IF, data: 64'h0000_0013,   chk: 1'b1});
        fork
            data_req(1'b0, 64'h100, 64'h0, lat_d);
            fetch_req(64'h0, lat_i);
        join
        check("contend_d_lat",  64'(lat_d), 64'(LAT1 + 2));
        check("contend_if_lat", 64'(lat_i), 64'(LAT1 + 2 + LAT1 + 3));

        // Continuous data stream versus a waiting fetch: 4 data wins, then the fetch.
        for (int i = 0; i < 4; i++) exp_q.push_back('{port: PORT_D, data: 64'h1234, chk: 1'b1});
        exp_q.push_back('{port: PORT_IF, data: 64'hAAAA_BBBB, chk: 1'b1});
        exp_q.push_back('{port: PORT_D,  data: 64'h1234,      chk: 1'b1});
        @(posedge clk); #1;
        ifc.d_we = 1'b0; ifc.d_addr = 64'h100; ifc.if_addr = 64'h4;
        ifc.d_req = 1'b1; ifc.if_req = 1'b1;
        nd = 0; nd_at_if = -1; got_if = 1'b0; done_s = 1'b0;
        for (int i = 0; i < 100 && !done_s; i++) begin
            @(negedge clk);
            if (ifc.d_ack) begin
                nd++;
                if (got_if) done_s = 1'b1;
            end
            if (ifc.if_ack) begin
                got_if   = 1'b1;
                nd_at_if = nd;
            end
            @(posedge clk); #1;
            if (got_if) ifc.if_req = 1'b0;
            if (done_s) ifc.d_req = 1'b0;
        end
        ifc.if_req = 1'b0;
        ifc.d_req  = 1'b0;
        check("starve_fetch_granted", {63'b0, got_if}, 64'd1);
        check("starve_d_before_if",   64'(nd_at_if), 64'd4);
        check("starve_d_total",       64'(nd), 64'd5);

        // MEM_LAT=3 instance: reset asserted while in WAIT abandons the access.
        @(posedge clk); #1;
        ifc3.d_req = 1'b1; ifc3.d_we = 1'b0; ifc3.d_addr = 64'h40; ifc3.d_wdata = 64'hFFFF;
        @(negedge clk);
        @(negedge clk);
        check("d3_issue_mem_en", {63'b0, ifc3.mem_en}, 64'd1);
        @(negedge clk);
        check("d3_wait_busy", {62'b0, ifc3.busy, ifc3.mem_en}, 64'b10);
        #2;
        reset3 = 1'b1;
        en3_0  = en3_cnt;
        ack3_0 = ack3_cnt;
        #1;
        check("d3_rst_busy",     {63'b0, ifc3.busy}, 64'd0);
        check("d3_rst_mem",      {62'b0, ifc3.mem_en, ifc3.mem_we}, 64'd0);
        check("d3_rst_mem_addr", ifc3.mem_addr | ifc3.mem_wdata, 64'd0);
        check("d3_rst_ack",      {63'b0, ifc3.d_ack}, 64'd0);
        check("d3_rst_rdata",    ifc3.d_rdata, 64'd0);
        repeat (3) @(negedge clk);
        reset3 = 1'b0;
        r = cyc;
        check("d3_no_ack_in_reset", 64'(ack3_cnt - ack3_0), 64'd0);
        lat3 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifc3.d_ack) begin
                lat3 = cyc - r;
                break;
            end
        end
        check("d3_reissue_latency", 64'(lat3), 64'(LAT3 + 2));
        check("d3_reissue_pulses",  64'(en3_cnt - en3_0), 64'd1);
        check("d3_reissue_rdata",   ifc3.d_rdata, 64'h5555_6666_7777_8888);
        @(posedge clk); #1;
        ifc3.d_req = 1'b0;
        repeat (8) @(negedge clk);
        check("d3_single_ack", 64'(ack3_cnt - ack3_0), 64'd1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("one_mem_en_per_ack", 64'(mem_en_cnt), 64'(ack_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
